// File: rtl/audio_in_pitch_detect_if.sv
// Codec input-FIFO handshake between the audio controller (master) and the pitch detector (slave).
interface audio_in_pitch_detect_if;
  logic        audio_in_available;
  logic [31:0] left_channel_audio_in;
  logic        read_audio_in;

  modport master (
    output audio_in_available,
    output left_channel_audio_in,
    input  read_audio_in
  );

  modport slave (
    input  audio_in_available,
    input  left_channel_audio_in,
    output read_audio_in
  );
endinterface

// File: rtl/audio_in_pitch_detect.sv
// Pops left-channel samples from the codec input FIFO, times rising zero crossings
// with hysteresis and locks onto one of the game notes B4 / G4 / F4.
module audio_in_pitch_detect #(
  parameter logic [15:0] THRESH      = 16'd512,
  parameter int          TOL         = 4,
  parameter int          MATCH_COUNT = 4,
  parameter int          MAX_PERIOD  = 255,
  parameter int          B4_PERIOD   = 97,
  parameter int          G4_PERIOD   = 122,
  parameter int          F4_PERIOD   = 137
) (
  input  logic                   CLOCK_50,
  input  logic                   resetn,
  audio_in_pitch_detect_if.slave codec,
  output logic [7:0]             period_out,
  output logic                   period_valid,
  output logic [2:0]             note_onehot,
  output logic                   note_valid
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PROC = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  localparam int MW = (MATCH_COUNT < 2) ? 1 : $clog2(MATCH_COUNT + 1);
  localparam logic [MW-1:0] MATCH_SAT = MW'(MATCH_COUNT);
  localparam logic [MW-1:0] MATCH_ONE = MW'(1);

  localparam logic [8:0] MAX9 = 9'(MAX_PERIOD);
  localparam logic [7:0] MAX8 = 8'(MAX_PERIOD);

  localparam logic signed [16:0] THR_POS = {1'b0, THRESH};
  localparam logic signed [16:0] THR_NEG = -THR_POS;

  localparam logic signed [8:0] TOL9 = 9'(TOL);
  localparam logic signed [8:0] B4_9 = 9'(B4_PERIOD);
  localparam logic signed [8:0] G4_9 = 9'(G4_PERIOD);
  localparam logic signed [8:0] F4_9 = 9'(F4_PERIOD);

  logic [1:0]          state;
  logic signed [15:0]  sample;
  logic                sign_hi;
  logic                armed;
  logic [7:0]          cnt;
  logic [MW-1:0]       match_cnt;
  logic [2:0]          cand;

  logic signed [16:0]  sample_ext;
  logic                new_sign;
  logic                rising;
  logic [8:0]          cnt_inc;
  logic                sat;
  logic                emit;
  logic [7:0]          p;
  logic [2:0]          cls;
  logic [MW-1:0]       match_next;
  logic [2:0]          cand_next;
  logic                lock;

  // Distance test done in 9-bit signed so periods below the nominal never wrap.
  function automatic logic near_nominal(input logic [7:0] period, input logic signed [8:0] nominal);
    logic signed [8:0] diff;
    logic signed [8:0] mag;
    diff = $signed({1'b0, period}) - nominal;
    mag  = diff[8] ? -diff : diff;
    return mag <= TOL9;
  endfunction

  assign codec.read_audio_in = resetn && (state == S_IDLE) && codec.audio_in_available;

  assign sample_ext = {sample[15], sample};
  assign new_sign   = (sample_ext > THR_POS) ? 1'b1 :
                      (sample_ext < THR_NEG) ? 1'b0 : sign_hi;
  assign rising     = new_sign & ~sign_hi;
  assign cnt_inc    = {1'b0, cnt} + 9'd1;
  assign sat        = cnt_inc >= MAX9;
  assign emit       = rising & armed & ~sat;
  assign p          = cnt_inc[7:0];

  always_comb begin
    cls = 3'b000;
    if (near_nominal(p, B4_9))      cls = 3'b100;
    else if (near_nominal(p, G4_9)) cls = 3'b010;
    else if (near_nominal(p, F4_9)) cls = 3'b001;
  end

  always_comb begin
    cand_next  = cand;
    match_next = match_cnt;
    if (cls == 3'b000) begin
      cand_next  = 3'b000;
      match_next = '0;
    end else if (cls == cand) begin
      match_next = (match_cnt >= MATCH_SAT) ? MATCH_SAT : match_cnt + MATCH_ONE;
    end else begin
      cand_next  = cls;
      match_next = MATCH_ONE;
    end
    lock = (cls != 3'b000) && (match_next == MATCH_SAT);
  end

  // WAIT gives the FIFO flag a cycle to settle, so pops are at least 3 cycles apart.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state  <= S_IDLE;
      sample <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (codec.audio_in_available) begin
            sample <= codec.left_channel_audio_in[31:16];
            state  <= S_PROC;
          end
        end
        S_PROC:  state <= S_WAIT;
        S_WAIT:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // A crossing that lands on the saturating sample counts as timeout plus re-arm.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      sign_hi      <= 1'b0;
      armed        <= 1'b0;
      cnt          <= '0;
      match_cnt    <= '0;
      cand         <= 3'b000;
      period_out   <= '0;
      period_valid <= 1'b0;
      note_onehot  <= 3'b000;
      note_valid   <= 1'b0;
    end else begin
      period_valid <= 1'b0;
      if (state == S_PROC) begin
        sign_hi <= new_sign;
        if (sat) begin
          note_onehot <= 3'b000;
          note_valid  <= 1'b0;
          match_cnt   <= '0;
          cand        <= 3'b000;
        end
        if (rising) begin
          cnt   <= '0;
          armed <= 1'b1;
          if (emit) begin
            period_out   <= p;
            period_valid <= 1'b1;
            match_cnt    <= match_next;
            cand         <= cand_next;
            if (lock) begin
              note_onehot <= cand_next;
              note_valid  <= |cand_next;
            end
          end
        end else if (sat) begin
          cnt   <= MAX8;
          armed <= 1'b0;
        end else begin
          cnt <= cnt_inc[7:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_audio_in_pitch_detect.sv
// Bench for audio_in_pitch_detect: queue-backed codec FIFO, per-sample reference model,
// a table of tone segments and hand-written reset / saturation sequences.
module tb_audio_in_pitch_detect;

  localparam int THRESH      = 512;
  localparam int TOL         = 4;
  localparam int MATCH_COUNT = 4;
  localparam int MAX_PERIOD  = 255;
  localparam int B4          = 97;
  localparam int G4          = 122;
  localparam int F4          = 137;
  localparam int AMP         = 16384;

  logic       CLOCK_50 = 1'b0;
  logic       resetn;
  logic [7:0] period_out;
  logic       period_valid;
  logic [2:0] note_onehot;
  logic       note_valid;

  audio_in_pitch_detect_if bus();

  audio_in_pitch_detect dut (
    .CLOCK_50     (CLOCK_50),
    .resetn       (resetn),
    .codec        (bus),
    .period_out   (period_out),
    .period_valid (period_valid),
    .note_onehot  (note_onehot),
    .note_valid   (note_valid)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    int valid;
    int periodOut;
    int note;
  } expRec_t;

  typedef struct {
    string name;
    int    period;
    int    reps;
    int    amp;
    int    expNote;
    int    expPeriod;
  } segVec_t;

  int          testsRun    = 0;
  int          testsFailed = 0;
  logic [31:0] fifoQ[$];
  bit          stallEnable = 1'b0;
  bit          stall       = 1'b0;
  bit          popPending  = 1'b0;
  bit          prevRead    = 1'b0;
  int          pulseCount  = 0;
  expRec_t     pipeExp[2];
  bit          pipeValid[2];

  // Reference model state: sample index based, history holds the current same-class run.
  int mIdx, mLastCross, mLastPeriod, mNote;
  bit mSignHigh, mArmed;
  int mHist[$];

  task automatic checkOutput(input string name, input int actual, input int expected);
    testsRun++;
    if (actual != expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    mIdx        = 0;
    mLastCross  = 0;
    mLastPeriod = 0;
    mNote       = 0;
    mSignHigh   = 1'b0;
    mArmed      = 1'b0;
    mHist.delete();
  endtask

  function automatic int classify(input int per);
    if (per - B4 >= -TOL && per - B4 <= TOL) return 4;
    if (per - G4 >= -TOL && per - G4 <= TOL) return 2;
    if (per - F4 >= -TOL && per - F4 <= TOL) return 1;
    return 0;
  endfunction

  task automatic modelStep(input int s, output expRec_t e);
    int gap, cls;
    bit newSign;
    mIdx++;
    gap     = mIdx - mLastCross;
    newSign = (s > THRESH) ? 1'b1 : ((s < -THRESH) ? 1'b0 : mSignHigh);
    e.valid = 0;
    if (newSign && !mSignHigh) begin
      if (gap >= MAX_PERIOD) begin
        mNote = 0;
        mHist.delete();
      end else if (mArmed) begin
        e.valid     = 1;
        mLastPeriod = gap;
        cls         = classify(gap);
        if (cls == 0) mHist.delete();
        else begin
          if (mHist.size() > 0 && mHist[$] != cls) mHist.delete();
          mHist.push_back(cls);
          if (mHist.size() >= MATCH_COUNT) mNote = cls;
        end
      end
      mArmed     = 1'b1;
      mLastCross = mIdx;
    end else if (gap == MAX_PERIOD) begin
      mNote  = 0;
      mArmed = 1'b0;
      mHist.delete();
    end
    mSignHigh   = newSign;
    e.periodOut = mLastPeriod;
    e.note      = mNote;
  endtask

  task automatic pushSample(input int s);
    logic [15:0] v;
    logic [15:0] junk;
    v    = 16'(s);
    junk = 16'($urandom);
    fifoQ.push_back({v, junk});
  endtask

  // period == 0 means a flat run of uniform noise within +/-amp; otherwise a square
  // wave that starts each repetition on its high half, so every repetition opens with a crossing.
  task automatic applyStimulus(input segVec_t v);
    if (v.period == 0) begin
      for (int i = 0; i < v.reps; i++)
        pushSample(int'($urandom_range(0, 2 * v.amp)) - v.amp);
    end else begin
      for (int r = 0; r < v.reps; r++) begin
        for (int i = 0; i < v.period - v.period / 2; i++) pushSample(v.amp);
        for (int i = 0; i < v.period / 2; i++) pushSample(-v.amp);
      end
    end
  endtask

  task automatic pushRep(input int period);
    segVec_t v;
    v = '{"rep", period, 1, AMP, 0, 0};
    applyStimulus(v);
  endtask

  task automatic waitDrain();
    int cycles, budget;
    cycles = 0;
    budget = fifoQ.size() * 6 + 50;
    while ((fifoQ.size() > 0 || pipeValid[0] || pipeValid[1] || popPending) && cycles < budget) begin
      @(posedge CLOCK_50);
      cycles++;
    end
    if (cycles >= budget) checkOutput("drain_timeout_left", fifoQ.size(), 0);
    repeat (4) @(posedge CLOCK_50);
  endtask

  task automatic checkState(input string name, input int expNote, input int expPeriod);
    @(negedge CLOCK_50);
    checkOutput({name, "_note"}, int'(note_onehot), expNote);
    checkOutput({name, "_note_valid"}, int'(note_valid), int'(expNote != 0));
    checkOutput({name, "_period_out"}, int'(period_out), expPeriod);
  endtask

  task automatic doReset();
    @(negedge CLOCK_50);
    #3 resetn = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    fifoQ.delete();
    modelReset();
    pulseCount = 0;
    repeat (2) @(negedge CLOCK_50);
    resetn = 1'b1;
  endtask

  // Codec FIFO model and per-sample scoreboard: results appear in the WAIT cycle, two negedges after the pop.
  initial begin : feeder
    expRec_t e;
    bus.audio_in_available    = 1'b0;
    bus.left_channel_audio_in = 32'h0;
    pipeValid[0] = 1'b0;
    pipeValid[1] = 1'b0;
    forever begin
      @(negedge CLOCK_50);
      if (!resetn) begin
        pipeValid[0] = 1'b0;
        pipeValid[1] = 1'b0;
        prevRead     = 1'b0;
        popPending   = 1'b0;
      end else begin
        if (pipeValid[1]) begin
          checkOutput("period_valid", int'(period_valid), pipeExp[1].valid);
          checkOutput("period_out", int'(period_out), pipeExp[1].periodOut);
          checkOutput("note_onehot", int'(note_onehot), pipeExp[1].note);
          checkOutput("note_valid", int'(note_valid), int'(pipeExp[1].note != 0));
        end else begin
          checkOutput("period_valid_idle", int'(period_valid), 0);
        end
        if (period_valid) pulseCount++;
        pipeExp[1]   = pipeExp[0];
        pipeValid[1] = pipeValid[0];
        pipeValid[0] = 1'b0;
        if (bus.read_audio_in) begin
          checkOutput("read_back_to_back", int'(prevRead), 0);
          if (fifoQ.size() > 0) begin
            modelStep(int'($signed(fifoQ[0][31:16])), e);
            pipeExp[0]   = e;
            pipeValid[0] = 1'b1;
            popPending   = 1'b1;
          end else begin
            checkOutput("read_with_empty_fifo", int'(bus.audio_in_available), 0);
          end
        end
        prevRead = bus.read_audio_in;
      end
      @(posedge CLOCK_50);
      #1;
      if (popPending && fifoQ.size() > 0) void'(fifoQ.pop_front());
      popPending = 1'b0;
      stall = stallEnable && ($urandom_range(0, 7) == 0);
      bus.audio_in_available    = (fifoQ.size() > 0) && !stall;
      bus.left_channel_audio_in = (fifoQ.size() > 0) ? fifoQ[0] : 32'h0;
    end
  end

  initial begin : watchdog
    #3000000;
    $display("[TB] FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    segVec_t segTable[8];
    int strobes, budget;

    segTable[0] = '{"noise_idle", 0,   300, 300, 0, 0};
    segTable[1] = '{"b4_lock",    B4,  5,   AMP, 4, 97};
    segTable[2] = '{"g4_pending", 119, 3,   AMP, 4, 119};
    segTable[3] = '{"g4_switch",  119, 2,   AMP, 2, 119};
    segTable[4] = '{"none_hold",  110, 2,   AMP, 2, 110};
    segTable[5] = '{"f4_lock",    F4,  5,   AMP, 1, 137};
    segTable[6] = '{"silence",    0,   300, 0,   0, 137};
    segTable[7] = '{"g4_relock",  G4,  5,   AMP, 2, 122};

    modelReset();
    resetn = 1'b1;
    #2 resetn = 1'b0;
    #3;
    checkOutput("reset_period_out", int'(period_out), 0);
    checkOutput("reset_period_valid", int'(period_valid), 0);
    checkOutput("reset_note", int'(note_onehot), 0);
    checkOutput("reset_note_valid", int'(note_valid), 0);
    for (int i = 0; i < 3; i++) pushSample(AMP);
    repeat (4) begin
      @(negedge CLOCK_50);
      checkOutput("read_in_reset", int'(bus.read_audio_in), 0);
    end
    fifoQ.delete();
    repeat (2) @(negedge CLOCK_50);
    resetn = 1'b1;

    strobes = 0;
    repeat (20) begin
      @(negedge CLOCK_50);
      strobes += int'(bus.read_audio_in);
    end
    checkOutput("strobes_without_available", strobes, 0);

    for (int i = 0; i < 40; i++) pushSample(0);
    @(posedge CLOCK_50);
    #2;
    strobes = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge CLOCK_50);
      checkOutput("strobe_pattern", int'(bus.read_audio_in), int'(k % 3 == 0));
      strobes += int'(bus.read_audio_in);
    end
    checkOutput("strobe_count_30_cycles", strobes, 10);
    waitDrain();

    stallEnable = 1'b1;
    doReset();
    for (int i = 0; i < 8; i++) begin
      applyStimulus(segTable[i]);
      waitDrain();
      checkState(segTable[i].name, segTable[i].expNote, segTable[i].expPeriod);
    end

    doReset();
    stallEnable = 1'b0;
    for (int r = 0; r < 5; r++) pushRep(B4);
    budget = 0;
    while (mIdx < 2 * B4 + 40 && budget < 5000) begin
      @(posedge CLOCK_50);
      budget++;
    end
    checkOutput("reach_third_period", int'(mIdx >= 2 * B4 + 40), 1);
    checkOutput("pre_reset_period_out", int'(period_out), 97);
    @(negedge CLOCK_50);
    #3 resetn = 1'b0;
    #1;
    checkOutput("async_reset_period_out", int'(period_out), 0);
    checkOutput("async_reset_period_valid", int'(period_valid), 0);
    checkOutput("async_reset_note", int'(note_onehot), 0);
    checkOutput("async_reset_note_valid", int'(note_valid), 0);
    checkOutput("async_reset_read", int'(bus.read_audio_in), 0);
    repeat (3) begin
      @(negedge CLOCK_50);
      checkOutput("read_held_in_reset", int'(bus.read_audio_in), 0);
    end
    fifoQ.delete();
    modelReset();
    pulseCount = 0;
    repeat (2) @(negedge CLOCK_50);
    resetn = 1'b1;
    stallEnable = 1'b1;
    for (int r = 0; r < 4; r++) pushRep(B4);
    waitDrain();
    checkState("relock_four_crossings", 0, 97);
    pushRep(B4);
    waitDrain();
    checkState("relock_five_crossings", 4, 97);

    doReset();
    pushRep(97);
    pushRep(255);
    pushRep(97);
    pushRep(254);
    pushRep(50);
    pushRep(256);
    pushRep(97);
    pushRep(97);
    waitDrain();
    checkOutput("saturation_pulse_count", pulseCount, 5);
    checkState("saturation_last", 0, 97);

    doReset();
    for (int seg = 0; seg < 12; seg++) begin
      segVec_t v;
      int kind, nom;
      kind = int'($urandom_range(0, 9));
      v.name = "random";
      v.expNote = 0;
      v.expPeriod = 0;
      if (kind == 0) begin
        v.period = 0;
        v.reps   = int'($urandom_range(50, 300));
        v.amp    = int'($urandom_range(0, 600));
      end else begin
        case ($urandom_range(0, 2))
          0:       nom = B4;
          1:       nom = G4;
          default: nom = F4;
        endcase
        v.period = (kind == 9) ? int'($urandom_range(20, 200)) : nom + int'($urandom_range(0, 12)) - 6;
        v.reps   = int'($urandom_range(1, 5));
        v.amp    = (kind == 1) ? int'($urandom_range(512, 513)) : int'($urandom_range(513, 32767));
      end
      applyStimulus(v);
    end
    waitDrain();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
